// File: rtl/traffic_intersection_ctrl_if.sv
// Signal bundle between the road sensors/buttons, the intersection
// controller and the lamp drivers.
interface traffic_intersection_ctrl_if;
  logic       car_side;
  logic       ped_req;
  logic       main_g;
  logic       main_y;
  logic       main_r;
  logic       side_g;
  logic       side_y;
  logic       side_r;
  logic       ped_walk;
  logic [2:0] state_o;

  // Sensor/button side: drives requests, watches lamps.
  modport master (
    output car_side, ped_req,
    input  main_g, main_y, main_r, side_g, side_y, side_r, ped_walk, state_o
  );

  // Controller side: reads requests, drives lamps.
  modport slave (
    input  car_side, ped_req,
    output main_g, main_y, main_r, side_g, side_y, side_r, ped_walk, state_o
  );
endinterface

// File: rtl/traffic_intersection_ctrl.sv
// Two-road intersection controller. The main road holds green by default;
// the side road gets a timed green after a latched car or pedestrian request,
// extended while side cars remain, up to a hard maximum.
package traffic_intersection_pkg;
  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;
endpackage

module traffic_intersection_ctrl
  import traffic_intersection_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1
) (
  input logic                        clk,
  input logic                        reset,
  traffic_intersection_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] D_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] D_SAT = '1;
  localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] Y_T   = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] AR_T  = CNT_W'(ALLRED_T);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] d_q, d_d;
  logic             side_pend_q, side_pend_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_grant_q, ped_grant_d;
  logic             demand;
  logic             enter_sg;

  assign demand = side_pend_q | ped_pend_q | bus.car_side | bus.ped_req;

  // Next-state decision from the current phase and its dwell count.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      MG:      if (d_q >= G_MIN && demand) state_d = MY;
      MY:      if (d_q == Y_T)             state_d = AR1;
      AR1:     if (d_q == AR_T)            state_d = SG;
      SG:      if ((d_q >= G_MIN && !bus.car_side) || d_q == G_MAX) state_d = SY;
      SY:      if (d_q == Y_T)             state_d = AR2;
      AR2:     if (d_q == AR_T)            state_d = MG;
      default:                             state_d = AR2;  // illegal code: recover via all-red
    endcase
  end

  // Dwell counter and request latches; entering SG consumes pending requests.
  always_comb begin
    enter_sg    = (state_q != SG) && (state_d == SG);
    d_d         = (state_d != state_q) ? D_ONE :
                  (d_q == D_SAT)       ? d_q   : d_q + D_ONE;
    side_pend_d = enter_sg ? 1'b0 : (side_pend_q | bus.car_side);
    ped_pend_d  = enter_sg ? 1'b0 : (ped_pend_q | bus.ped_req);
    ped_grant_d = enter_sg ? (ped_pend_q | bus.ped_req) : ped_grant_q;
  end

  // State register and bookkeeping, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MG;
      d_q         <= D_ONE;
      side_pend_q <= 1'b0;
      ped_pend_q  <= 1'b0;
      ped_grant_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q     <= state_d;
      d_q         <= d_d;
      side_pend_q <= side_pend_d;
      ped_pend_q  <= ped_pend_d;
      ped_grant_q <= ped_grant_d;
    end
  end

  // Moore lamp decode from the state register only; unknown codes show all-red.
  always_comb begin
    bus.main_g   = 1'b0;
    bus.main_y   = 1'b0;
    bus.main_r   = 1'b0;
    bus.side_g   = 1'b0;
    bus.side_y   = 1'b0;
    bus.side_r   = 1'b0;
    case (state_q)
      MG: begin bus.main_g = 1'b1; bus.side_r = 1'b1; end
      MY: begin bus.main_y = 1'b1; bus.side_r = 1'b1; end
      SG: begin bus.main_r = 1'b1; bus.side_g = 1'b1; end
      SY: begin bus.main_r = 1'b1; bus.side_y = 1'b1; end
      default: begin bus.main_r = 1'b1; bus.side_r = 1'b1; end
    endcase
    bus.ped_walk = (state_q == SG) && (d_q <= G_MIN) && ped_grant_q;
  end

  assign bus.state_o = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench for traffic_intersection_ctrl: per-cycle expectations
// (state code + walk) are queued and compared against the lamps each cycle.
module tb_traffic_intersection_ctrl;

  localparam logic [2:0] S_MG = 3'd0, S_MY = 3'd1, S_AR1 = 3'd2,
                         S_SG = 3'd3, S_SY = 3'd4, S_AR2 = 3'd5;
  localparam int GMIN = 4, GMAX = 10, YT = 2, ART = 1, DSAT = 15;

  typedef struct packed {
    logic [2:0] st;
    logic       walk;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  traffic_intersection_ctrl_if tif ();

  traffic_intersection_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tif)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Reference model state for the random scenario.
  logic [2:0] m_st;
  int         m_d;
  logic       m_sp, m_pp, m_pg;

  // Expected {state, main g/y/r, side g/y/r, walk} for a queued entry.
  function automatic logic [9:0] expect_vec(input exp_t e);
    logic [5:0] lamps;
    case (e.st)
      S_MG:    lamps = 6'b100_001;
      S_MY:    lamps = 6'b010_001;
      S_SG:    lamps = 6'b001_100;
      S_SY:    lamps = 6'b001_010;
      default: lamps = 6'b001_001;
    endcase
    return {e.st, lamps, e.walk};
  endfunction

  function automatic logic [9:0] observed();
    return {tif.state_o, tif.main_g, tif.main_y, tif.main_r,
            tif.side_g, tif.side_y, tif.side_r, tif.ped_walk};
  endfunction

  task automatic push_run(input logic [2:0] s, input logic w, input int n);
    exp_t e;
    e.st   = s;
    e.walk = w;
    repeat (n) exp_q.push_back(e);
  endtask

  // Reset with quiet inputs; released on a falling edge.
  task automatic do_reset();
    reset        = 1'b1;
    tif.car_side = 1'b0;
    tif.ped_req  = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One clocked step of the behavioural spec model; queues next-cycle outputs.
  task automatic model_step(input logic car, input logic ped);
    logic [2:0] nx;
    logic       dem;
    exp_t       e;
    dem = m_sp | m_pp | car | ped;
    nx  = m_st;
    if (m_st > S_AR2)                                  nx = S_AR2;
    else if (m_st == S_MG  && m_d >= GMIN && dem)      nx = S_MY;
    else if (m_st == S_MY  && m_d == YT)               nx = S_AR1;
    else if (m_st == S_AR1 && m_d == ART)              nx = S_SG;
    else if (m_st == S_SG  && ((m_d >= GMIN && !car) || m_d == GMAX)) nx = S_SY;
    else if (m_st == S_SY  && m_d == YT)               nx = S_AR2;
    else if (m_st == S_AR2 && m_d == ART)              nx = S_MG;
    if (nx == S_SG && m_st != S_SG) begin
      m_pg = m_pp | ped;
      m_sp = 1'b0;
      m_pp = 1'b0;
    end else begin
      m_sp = m_sp | car;
      m_pp = m_pp | ped;
    end
    if (nx != m_st)     m_d = 1;
    else if (m_d < DSAT) m_d = m_d + 1;
    m_st   = nx;
    e.st   = m_st;
    e.walk = (m_st == S_SG) && (m_d <= GMIN) && m_pg;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    int   k;
    #1;
    e.st = S_MG; e.walk = 1'b0;
    checks++;
    if (observed() !== expect_vec(e)) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", observed(), expect_vec(e));
    end
    do_reset();
    push_run(S_MG, 1'b0, 50);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== expect_vec(e)) begin
        failures++;
        $display("FAIL idle_mg cycle %0d: got %b expected %b", k, observed(), expect_vec(e));
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_car_held();
    exp_t e;
    int   k;
    do_reset();
    tif.car_side = 1'b1;
    push_run(S_MG, 0, 4);  push_run(S_MY, 0, 2); push_run(S_AR1, 0, 1);
    push_run(S_SG, 0, 10); push_run(S_SY, 0, 2); push_run(S_AR2, 0, 1);
    push_run(S_MG, 0, 4);  push_run(S_MY, 0, 1);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== expect_vec(e)) begin
        failures++;
        $display("FAIL car_held cycle %0d: got %b expected %b", k, observed(), expect_vec(e));
      end
      @(negedge clk);
      k++;
    end
    tif.car_side = 1'b0;
  endtask

  task automatic test_car_pulse();
    exp_t e;
    int   k;
    do_reset();
    push_run(S_MG, 0, 7);  push_run(S_MY, 0, 2); push_run(S_AR1, 0, 1);
    push_run(S_SG, 0, 4);  push_run(S_SY, 0, 2); push_run(S_AR2, 0, 1);
    push_run(S_MG, 0, 10);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== expect_vec(e)) begin
        failures++;
        $display("FAIL car_pulse cycle %0d: got %b expected %b", k, observed(), expect_vec(e));
      end
      tif.car_side = (k == 6);
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_ped();
    exp_t e;
    int   k;
    do_reset();
    push_run(S_MG, 0, 4);  push_run(S_MY, 0, 2); push_run(S_AR1, 0, 1);
    push_run(S_SG, 1, 4);  push_run(S_SY, 0, 2); push_run(S_AR2, 0, 1);
    push_run(S_MG, 0, 4);  push_run(S_MY, 0, 2); push_run(S_AR1, 0, 1);
    push_run(S_SG, 1, 4);  push_run(S_SG, 0, 6); push_run(S_SY, 0, 2);
    push_run(S_AR2, 0, 1); push_run(S_MG, 0, 4); push_run(S_MY, 0, 1);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== expect_vec(e)) begin
        failures++;
        $display("FAIL ped_round cycle %0d: got %b expected %b", k, observed(), expect_vec(e));
      end
      tif.ped_req = (k == 0) || (k == 11);
      if (k == 11) tif.car_side = 1'b1;
      if (k == 30) tif.car_side = 1'b0;
      @(negedge clk);
      k++;
    end
    tif.car_side = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   k;
    do_reset();
    push_run(S_MG, 0, 4); push_run(S_MY, 0, 2); push_run(S_AR1, 0, 1);
    push_run(S_SG, 1, 3);
    for (k = 0; k < 10; k++) begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== expect_vec(e)) begin
        failures++;
        $display("FAIL pre_reset cycle %0d: got %b expected %b", k, observed(), expect_vec(e));
      end
      tif.car_side = (k == 0);
      tif.ped_req  = (k == 0);
      if (k < 9) @(negedge clk);
    end
    // Mid-SG reset must act without waiting for a clock edge.
    reset = 1'b1;
    #1;
    e.st = S_MG; e.walk = 1'b0;
    checks++;
    if (observed() !== expect_vec(e)) begin
      failures++;
      $display("FAIL async_reset: got %b expected %b", observed(), expect_vec(e));
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push_run(S_MG, 0, 20);
    k = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== expect_vec(e)) begin
        failures++;
        $display("FAIL post_reset cycle %0d: got %b expected %b", k, observed(), expect_vec(e));
      end
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic car, ped, inv_ok;
    do_reset();
    m_st = S_MG; m_d = 1; m_sp = 1'b0; m_pp = 1'b0; m_pg = 1'b0;
    push_run(S_MG, 0, 1);
    for (int n = 0; n < 10000; n++) begin
      e = exp_q.pop_front();
      checks++;
      if (observed() !== expect_vec(e)) begin
        failures++;
        $display("FAIL random cycle %0d: got %b expected %b", n, observed(), expect_vec(e));
      end
      inv_ok = ($countones({tif.main_g, tif.main_y, tif.main_r}) == 1) &&
               ($countones({tif.side_g, tif.side_y, tif.side_r}) == 1) &&
               !((tif.main_g | tif.main_y) & (tif.side_g | tif.side_y)) &&
               (!tif.ped_walk || tif.main_r);
      checks++;
      if (inv_ok !== 1'b1) begin
        failures++;
        $display("FAIL invariants cycle %0d: got %b expected 1", n, inv_ok);
      end
      if (n == 5000) begin
        force dut.state_q = traffic_intersection_pkg::state_t'(3'd7);
        #1;
        e.st = 3'd7; e.walk = 1'b0;
        checks++;
        if (observed() !== expect_vec(e)) begin
          failures++;
          $display("FAIL illegal_state: got %b expected %b", observed(), expect_vec(e));
        end
        release dut.state_q;
        #1;
        m_st = 3'd7;
      end
      car = ($urandom_range(0, 3) == 0);
      ped = ($urandom_range(0, 15) == 0);
      tif.car_side = car;
      tif.ped_req  = ped;
      model_step(car, ped);
      @(negedge clk);
    end
    tif.car_side = 1'b0;
    tif.ped_req  = 1'b0;
  endtask

  initial begin
    tif.car_side = 1'b0;
    tif.ped_req  = 1'b0;
    test_reset();
    test_car_held();
    test_car_pulse();
    test_ped();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
